// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: load/store and program-counter controller.
// Accepts one operation per handshake. ALU and ADR ops write back in a
// single cycle. LDR/STR ops issue a memory request and wait for mem_ack,
// giving up after TIMEOUT cycles. The PC advances by PC_STEP on every
// completed operation.
module mem_access_ctrl #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned PC_STEP = 1,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [3:0]        op_code,
    input  logic [DATA_W-1:0] SR1,
    input  logic [DATA_W-1:0] SR2,
    input  logic [DATA_W-1:0] alu_result,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] reg_data,
    output logic              reg_we,
    output logic [ADDR_W-1:0] pc,
    output logic              err
);

    localparam logic [3:0] OP_LDR = 4'b1101;
    localparam logic [3:0] OP_STR = 4'b1110;
    localparam logic [3:0] OP_ADR = 4'b1100;

    // Wait counter only needs to reach TIMEOUT-1.
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] PC_INC  = ADDR_W'(PC_STEP);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MEM  = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             accept;
    logic             is_mem_op;

    // Upper address-source bits are not used when DATA_W exceeds ADDR_W.
    if (DATA_W > ADDR_W) begin : g_sr1_hi
        logic unused_sr1_hi;
        assign unused_sr1_hi = ^SR1[DATA_W-1:ADDR_W];
    end

    // Handshake: ready only in IDLE and never while reset is asserted.
    always_comb begin
        op_ready  = (state == ST_IDLE) && Reset;
        accept    = op_valid && op_ready;
        is_mem_op = (op_code == OP_LDR) || (op_code == OP_STR);
    end

    // Control FSM with all outputs registered; reg_we self-clears each cycle.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            pc        <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            reg_data  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            reg_we    <= 1'b0;
            err       <= 1'b0;
        end else begin
            reg_we <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (is_mem_op) begin
                            mem_req  <= 1'b1;
                            mem_addr <= SR1[ADDR_W-1:0];
                            mem_we   <= (op_code == OP_STR);
                            if (op_code == OP_STR) begin
                                mem_wdata <= SR2;
                            end
                            wait_cnt <= '0;
                            state    <= ST_MEM;
                        end else begin
                            reg_data <= (op_code == OP_ADR) ? SR1 : alu_result;
                            reg_we   <= 1'b1;
                            pc       <= pc + PC_INC;
                        end
                    end
                end
                ST_MEM: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        pc      <= pc + PC_INC;
                        // mem_we is held from accept, so it identifies LDR here.
                        if (!mem_we) begin
                            reg_data <= mem_rdata;
                            reg_we   <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end else if (wait_cnt == CNT_LAST) begin
                        mem_req <= 1'b0;
                        err     <= 1'b1;
                        state   <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed, table-driven bench for mem_access_ctrl
// with default parameters (DATA_W=32, ADDR_W=8, PC_STEP=1, TIMEOUT=15).
module tb_mem_access_ctrl;

    localparam logic [3:0] LDR = 4'b1101;
    localparam logic [3:0] STR = 4'b1110;
    localparam logic [3:0] ADR = 4'b1100;
    localparam logic [3:0] ALU = 4'b0001;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        op_valid;
    logic        op_ready;
    logic [3:0]  op_code;
    logic [31:0] SR1, SR2, alu_result;
    logic        mem_req, mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_ack;
    logic [31:0] reg_data;
    logic        reg_we;
    logic [7:0]  pc;
    logic        err;

    int total = 0;
    int bad   = 0;

    mem_access_ctrl #(
        .DATA_W(32),
        .ADDR_W(8),
        .PC_STEP(1),
        .TIMEOUT(15)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .op_valid(op_valid),
        .op_ready(op_ready),
        .op_code(op_code),
        .SR1(SR1),
        .SR2(SR2),
        .alu_result(alu_result),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack(mem_ack),
        .reg_data(reg_data),
        .reg_we(reg_we),
        .pc(pc),
        .err(err)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        // stimulus
        logic        valid;
        logic [3:0]  code;
        logic [31:0] sr1;
        logic [31:0] sr2;
        logic [31:0] alu;
        logic        ack;
        logic [31:0] rdata;
        // expected after the edge
        logic        e_req;
        logic        e_we;
        logic [7:0]  e_addr;
        logic [31:0] e_wdata;
        logic        e_rwe;
        logic [31:0] e_rdat;
        logic [7:0]  e_pc;
        logic        e_err;
        logic        e_rdy;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag,
                              input logic e_req, input logic e_we,
                              input logic [7:0] e_addr, input logic [31:0] e_wdata,
                              input logic e_rwe, input logic [31:0] e_rdat,
                              input logic [7:0] e_pc, input logic e_err,
                              input logic e_rdy);
        chk({tag, ".mem_req"},   32'(mem_req),   32'(e_req));
        chk({tag, ".mem_we"},    32'(mem_we),    32'(e_we));
        chk({tag, ".mem_addr"},  32'(mem_addr),  32'(e_addr));
        chk({tag, ".mem_wdata"}, mem_wdata,      e_wdata);
        chk({tag, ".reg_we"},    32'(reg_we),    32'(e_rwe));
        chk({tag, ".reg_data"},  reg_data,       e_rdat);
        chk({tag, ".pc"},        32'(pc),        32'(e_pc));
        chk({tag, ".err"},       32'(err),       32'(e_err));
        chk({tag, ".op_ready"},  32'(op_ready),  32'(e_rdy));
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] c, input logic [31:0] s1,
                         input logic [31:0] s2, input logic [31:0] a,
                         input logic k, input logic [31:0] rd);
        op_valid   = v;
        op_code    = c;
        SR1        = s1;
        SR2        = s2;
        alu_result = a;
        mem_ack    = k;
        mem_rdata  = rd;
    endtask

    int hi;

    initial begin
        // Field order: valid code sr1 sr2 alu ack rdata | req we addr wdata rwe rdat pc err rdy
        vecs[0]  = '{1'b1, ALU, 32'h0,     32'h0,         32'd5,  1'b0, 32'h0,
                     1'b0, 1'b0, 8'h00, 32'h0,         1'b1, 32'd5,         8'd1, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, ALU, 32'h0,     32'h0,         32'd6,  1'b0, 32'h0,
                     1'b0, 1'b0, 8'h00, 32'h0,         1'b1, 32'd6,         8'd2, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, ALU, 32'h0,     32'h0,         32'd7,  1'b0, 32'h0,
                     1'b0, 1'b0, 8'h00, 32'h0,         1'b1, 32'd7,         8'd3, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, ALU, 32'h0,     32'h0,         32'd99, 1'b0, 32'h0,
                     1'b0, 1'b0, 8'h00, 32'h0,         1'b0, 32'd7,         8'd3, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, STR, 32'h34,    32'hA5A5A5A5,  32'd0,  1'b0, 32'h0,
                     1'b1, 1'b1, 8'h34, 32'hA5A5A5A5,  1'b0, 32'd7,         8'd3, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, ALU, 32'h0,     32'h0,         32'd0,  1'b1, 32'h5555,
                     1'b0, 1'b1, 8'h34, 32'hA5A5A5A5,  1'b0, 32'd7,         8'd4, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, ADR, 32'h12340009, 32'h0,      32'd0,  1'b0, 32'h0,
                     1'b0, 1'b1, 8'h34, 32'hA5A5A5A5,  1'b1, 32'h12340009,  8'd5, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, LDR, 32'h1AB,   32'hFFFF0000,  32'd0,  1'b0, 32'h0,
                     1'b1, 1'b0, 8'hAB, 32'hA5A5A5A5,  1'b0, 32'h12340009,  8'd5, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, ALU, 32'h0,     32'h0,         32'd77, 1'b0, 32'h0,
                     1'b1, 1'b0, 8'hAB, 32'hA5A5A5A5,  1'b0, 32'h12340009,  8'd5, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, ALU, 32'h0,     32'h0,         32'd0,  1'b1, 32'h11223344,
                     1'b0, 1'b0, 8'hAB, 32'hA5A5A5A5,  1'b1, 32'h11223344,  8'd6, 1'b0, 1'b1};
        vecs[10] = '{1'b0, ALU, 32'h0,     32'h0,         32'd0,  1'b1, 32'hFFFFFFFF,
                     1'b0, 1'b0, 8'hAB, 32'hA5A5A5A5,  1'b0, 32'h11223344,  8'd6, 1'b0, 1'b1};

        // Reset low for two cycles
        Reset = 1'b0;
        drive(1'b0, ALU, '0, '0, '0, 1'b0, '0);
        cyc();
        cyc();
        check_outs("reset", 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 32'h0, 8'd0, 1'b0, 1'b0);
        Reset = 1'b1;
        cyc();
        check_outs("post_reset", 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 32'h0, 8'd0, 1'b0, 1'b1);

        // Table-driven single-cycle vectors
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].valid, vecs[i].code, vecs[i].sr1, vecs[i].sr2,
                  vecs[i].alu, vecs[i].ack, vecs[i].rdata);
            cyc();
            check_outs($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_we, vecs[i].e_addr,
                       vecs[i].e_wdata, vecs[i].e_rwe, vecs[i].e_rdat, vecs[i].e_pc,
                       vecs[i].e_err, vecs[i].e_rdy);
        end

        // LDR with three wait cycles
        drive(1'b1, LDR, 32'h12, 32'h0, 32'h0, 1'b0, 32'h0);
        cyc();
        check_outs("ldr_acc", 1'b1, 1'b0, 8'h12, 32'hA5A5A5A5, 1'b0, 32'h11223344, 8'd6, 1'b0, 1'b0);
        drive(1'b0, ALU, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        for (int w = 0; w < 3; w++) begin
            cyc();
            check_outs($sformatf("ldr_wait%0d", w), 1'b1, 1'b0, 8'h12, 32'hA5A5A5A5,
                       1'b0, 32'h11223344, 8'd6, 1'b0, 1'b0);
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        cyc();
        check_outs("ldr_ack", 1'b0, 1'b0, 8'h12, 32'hA5A5A5A5, 1'b1, 32'hDEADBEEF, 8'd7, 1'b0, 1'b1);
        mem_ack = 1'b0;
        cyc();
        check_outs("ldr_after", 1'b0, 1'b0, 8'h12, 32'hA5A5A5A5, 1'b0, 32'hDEADBEEF, 8'd7, 1'b0, 1'b1);

        // LDR timeout with no ack
        drive(1'b1, LDR, 32'h40, 32'h0, 32'h0, 1'b0, 32'h0);
        cyc();
        drive(1'b0, ALU, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        hi = mem_req ? 1 : 0;
        for (int w = 0; w < 40; w++) begin
            if (!mem_req) break;
            cyc();
            if (mem_req) hi++;
        end
        chk("timeout.req_cycles", 32'(hi), 32'd15);
        check_outs("timeout", 1'b0, 1'b0, 8'h40, 32'hA5A5A5A5, 1'b0, 32'hDEADBEEF, 8'd7, 1'b1, 1'b1);
        drive(1'b1, ADR, 32'd9, 32'h0, 32'h0, 1'b0, 32'h0);
        cyc();
        check_outs("adr_after_to", 1'b0, 1'b0, 8'h40, 32'hA5A5A5A5, 1'b1, 32'd9, 8'd8, 1'b1, 1'b1);

        // Reset asserted during MEM, then a late ack
        drive(1'b1, LDR, 32'h55, 32'h0, 32'h0, 1'b0, 32'h0);
        cyc();
        chk("rst_mem.req_before", 32'(mem_req), 32'd1);
        drive(1'b0, ALU, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        Reset = 1'b0;
        cyc();
        check_outs("rst_mem", 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 32'h0, 8'd0, 1'b0, 1'b0);
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        cyc();
        check_outs("rst_hold", 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 32'h0, 8'd0, 1'b0, 1'b0);
        Reset = 1'b1;
        cyc();
        check_outs("late_ack", 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 32'h0, 8'd0, 1'b0, 1'b1);
        mem_ack = 1'b0;

        // PC wrap: 255 ALU ops reach 255, one more wraps to 0
        drive(1'b1, ALU, 32'h0, 32'h0, 32'd3, 1'b0, 32'h0);
        for (int k = 0; k < 255; k++) cyc();
        chk("wrap.pc255", 32'(pc), 32'd255);
        cyc();
        chk("wrap.pc0", 32'(pc), 32'd0);
        chk("wrap.reg_we", 32'(reg_we), 32'd1);
        op_valid = 1'b0;
        cyc();
        chk("wrap.reg_we_clear", 32'(reg_we), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time guard so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Parametrised load/store and program-counter controller sitting between the decode/ALU stage and the data memory. It accepts one operation per handshake, issues memory reads (LDR) and writes (STR) with a req/ack protocol and a bounded wait, and returns a result to the register file (ADR, ALU results, loaded data). It maintains the PC, advancing it by a configurable step on every successfully completed operation.

## Interface

Parameters:

- DATA_W, default 32: data, register-operand and result width.
- ADDR_W, default 8: memory address width and PC width.
- PC_STEP, default 1: PC increment per completed operation.
- TIMEOUT, default 15: maximum cycles to wait for mem_ack; must be ≥1.

Ports (name, direction, width, meaning):

- Clk, in, 1: clock; all state updates on the rising edge.
- Reset, in, 1: reset; synchronous, active-low.
- op_valid, in, 1: operation presented.
- op_ready, out, 1: controller can accept an operation.
- op_code, in, 4: 1101 LDR, 1110 STR, 1100 ADR, any other value is an ALU op.
- SR1, in, DATA_W: address source for LDR/STR, value for ADR.
- SR2, in, DATA_W: store data.
- alu_result, in, DATA_W: result for ALU ops.
- mem_req, out, 1: memory request.
- mem_we, out, 1: 1 = write, 0 = read; valid while mem_req is high.
- mem_addr, out, ADDR_W: memory address.
- mem_wdata, out, DATA_W: write data.
- mem_rdata, in, DATA_W: read data; valid in the cycle mem_ack is high.
- mem_ack, in, 1: memory completion.
- reg_data, out, DATA_W: write-back value.
- reg_we, out, 1: one-cycle write-back strobe.
- pc, out, ADDR_W: program counter.
- err, out, 1: sticky timeout flag.

## Operation

- States are IDLE and MEM. Reset state is IDLE.
- op_ready = (state==IDLE) && Reset. It is combinational.
- An operation is accepted when op_valid && op_ready at a rising edge. Operands are sampled only at accept.
- Accepting an ALU op:
  - reg_data <= alu_result, reg_we <= 1.
  - pc <= pc + PC_STEP.
  - State stays IDLE.
- Accepting an ADR op:
  - reg_data <= SR1, reg_we <= 1.
  - pc <= pc + PC_STEP.
  - State stays IDLE.
- Accepting an LDR or STR op:
  - mem_req <= 1, mem_addr <= SR1[ADDR_W-1:0].
  - mem_we <= (STR), mem_wdata <= SR2 for STR; mem_wdata is unchanged for LDR.
  - Wait counter <= 0, state <= MEM.
- In MEM, each cycle:
  - If mem_ack: mem_req <= 0 and pc <= pc + PC_STEP. For LDR, reg_data <= mem_rdata and reg_we <= 1. For STR, reg_we stays 0. State <= IDLE.
  - Else, if counter == TIMEOUT-1: mem_req <= 0, err <= 1, state <= IDLE. pc and reg_data are unchanged.
  - Else: counter <= counter + 1.
- mem_ack sampled in IDLE is ignored.
- mem_addr, mem_we and mem_wdata hold stable while mem_req is high.
- reg_we is high for exactly one cycle per write-back and is cleared on the next edge otherwise.
- pc wraps modulo 2^ADDR_W.
- err is cleared only by reset.
- Reset has priority over everything, including mid-MEM:
  - state = IDLE.
  - pc, mem_addr, mem_wdata, reg_data = 0.
  - mem_req, mem_we, reg_we, err = 0.
  - op_ready = 0 while Reset is low.

## Timing

- ALU/ADR op accepted at edge N: reg_we and reg_data valid after N, pc updated after N. op_ready stays high, so back-to-back accepts at one per cycle are allowed.
- LDR/STR op accepted at edge N: mem_req is high after N.
- mem_ack high at edge M: mem_req low, reg_we (LDR) and the new pc valid after M. op_ready is high again after M.
- Zero-wait memory (ack at the first cycle of MEM) gives 2 cycles from accept to next accept.
- Timeout: with no ack, mem_req stays high for exactly TIMEOUT cycles.
- All outputs except op_ready are registered.

## Test plan

- Reset low for 2 cycles, then high: all outputs 0, then op_ready=1 and pc=0.
- Three back-to-back ALU ops with alu_result = 5, 6, 7: reg_we high 3 consecutive cycles with reg_data 5, 6, 7. pc = 3·PC_STEP.
- LDR with SR1=0x12, memory acks after 3 wait cycles with rdata=0xDEADBEEF: mem_addr=0x12 and mem_we=0 held for 4 cycles. reg_data=0xDEADBEEF with one reg_we pulse. pc+PC_STEP. op_ready low throughout MEM.
- STR with SR1=0x34, SR2=0xA5A5A5A5, immediate ack: mem_we=1, mem_wdata=0xA5A5A5A5, no reg_we pulse, pc advances.
- LDR with no ack, TIMEOUT=15: mem_req high exactly 15 cycles, then err=1 and pc unchanged. A following ADR with SR1=9 gives reg_data=9, and err stays 1.
- Reset asserted during MEM: mem_req drops at the next edge, all outputs reset. A late mem_ack after reset has no effect. pc=255 with PC_STEP=1 plus one ALU op wraps pc to 0.
